// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the instruction memory and the cpu control unit.
// FETCH_SINGLE_STEP_EN adds the 'step' input used by the single-step HOLD state.
interface fetch_sequencer_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       d_inst;
  logic              run;
  logic              done;
  logic [1:0]        cmp_res;
  logic [ADDR_W-1:0] pc;
  logic              busy;
`ifdef FETCH_SINGLE_STEP_EN
  logic              step;
`endif

  modport master (
`ifdef FETCH_SINGLE_STEP_EN
    input  step,
`endif
    input  start, mem_data, done, cmp_res,
    output mem_addr, d_inst, run, pc, busy
  );

  modport slave (
`ifdef FETCH_SINGLE_STEP_EN
    output step,
`endif
    output start, mem_data, done, cmp_res,
    input  mem_addr, d_inst, run, pc, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-issue side of the cpu run/done handshake: owns the PC, fetches, issues, resolves branches.
// Optional FETCH_SINGLE_STEP_EN: after each instruction wait in HOLD for a 'step' pulse.
module fetch_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  // state  | meaning
  // IDLE   | stopped, waiting for start
  // FETCH  | mem_addr = pc, memory read in flight
  // LATCH  | capture mem_data into d_inst
  // ISSUE  | run pulse to cpu
  // EXEC   | wait for done
  // UPDATE | compute next pc, drive it to memory
  // HOLD   | single-step only: wait for step
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_EXEC,
`ifdef FETCH_SINGLE_STEP_EN
    S_HOLD,
`endif
    S_UPDATE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       d_inst_q, d_inst_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;

  logic [1:0]        fmt;
  logic [1:0]        cond;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;

  // Branch target is the 12-bit immediate fitted to the PC width.
  always_comb begin
    fmt     = d_inst_q[1:0];
    cond    = d_inst_q[3:2];
    taken   = (fmt == 2'b10) && (cond != 2'b11) && (cond == bus.cmp_res);
    target  = ADDR_W'(d_inst_q[15:4]);
    next_pc = taken ? target : (pc_q + ADDR_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    d_inst_d   = d_inst_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        d_inst_d = bus.mem_data;
        state_d  = S_ISSUE;
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC:  if (bus.done) state_d = S_UPDATE;
      S_UPDATE: begin
        pc_d       = next_pc;
        mem_addr_d = next_pc;
`ifdef FETCH_SINGLE_STEP_EN
        state_d    = bus.start ? S_HOLD : S_IDLE;
`else
        state_d    = bus.start ? S_FETCH : S_IDLE;
`endif
      end
`ifdef FETCH_SINGLE_STEP_EN
      S_HOLD: begin
        if (!bus.start)   state_d = S_IDLE;
        else if (bus.step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    run_d  = (state_d == S_ISSUE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      d_inst_q   <= 16'h0000;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      d_inst_q   <= d_inst_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.d_inst   = d_inst_q;
  assign bus.run      = run_q;
  assign bus.pc       = pc_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized check of fetch_sequencer against a program-flow reference model.
// Honours FETCH_SINGLE_STEP_EN when defined (step pulse needed between instructions).
module tb_fetch_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   ref_pc;
  logic [15:0] mem [256];

  fetch_sequencer_if #(.ADDR_W(8)) bus ();

  fetch_sequencer #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory: one cycle read latency
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_next(input int pc, input logic [15:0] inst, input logic [1:0] cmp);
    if (inst[1:0] == 2'b10 && inst[3:2] != 2'b11 && inst[3:2] == cmp)
      return (int'(inst) >> 4) % 256;
    return (pc + 1) % 256;
  endfunction

  task automatic wait_run(output int n);
    n = 0;
    while (bus.run !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.run !== 1'b1) check("run_timeout", 32'(bus.run), 32'd1);
  endtask

  // Entered in the ISSUE cycle; leaves at the next ISSUE cycle, or in IDLE when drop=1.
  task automatic exec_one(input logic [1:0] cmp, input int dly, input bit drop);
    logic [15:0] inst;
    int n;
    inst = mem[ref_pc];
    check("issue_pc", 32'(bus.pc), 32'(ref_pc));
    check("issue_d_inst", 32'(bus.d_inst), 32'(inst));
    check("issue_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= dly; i++) begin
      tick();
      bus.cmp_res = 2'($urandom_range(0, 3));
      if (i == 1 && drop) bus.start = 1'b0;
      check("exec_run_low", 32'(bus.run), 32'd0);
      check("exec_d_inst_stable", 32'(bus.d_inst), 32'(inst));
      if (i == dly) bus.done = 1'b1;
    end
    tick();
    bus.done    = 1'b0;
    bus.cmp_res = cmp;
    check("update_d_inst_stable", 32'(bus.d_inst), 32'(inst));
    check("update_run_low", 32'(bus.run), 32'd0);
    ref_pc = ref_next(ref_pc, inst, cmp);
    bus.cmp_res = 2'($urandom_range(0, 3));
    bus.cmp_res = cmp;
    tick();
    bus.cmp_res = 2'($urandom_range(0, 3));
    check("next_pc", 32'(bus.pc), 32'(ref_pc));
    check("next_mem_addr", 32'(bus.mem_addr), 32'(ref_pc));
    if (drop) begin
      check("drop_idle_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
        tick();
        check("idle_no_run", 32'(bus.run), 32'd0);
        check("idle_pc_hold", 32'(bus.pc), 32'(ref_pc));
      end
      check("idle_busy", 32'(bus.busy), 32'd0);
    end else begin
`ifdef FETCH_SINGLE_STEP_EN
      for (int i = 0; i < 3; i++) begin
        check("hold_no_run", 32'(bus.run), 32'd0);
        check("hold_busy", 32'(bus.busy), 32'd1);
        tick();
      end
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      wait_run(n);
      check("step_to_run", 32'(n + 1), 32'd3);
`else
      wait_run(n);
      check("fetch_to_run", 32'(n), 32'd2);
`endif
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
    mem[8'h00] = 16'h2001;
    mem[8'h01] = 16'h0052;
    mem[8'h05] = 16'h0A02;
    mem[8'hA0] = 16'h0052;
    mem[8'h06] = 16'h005E;
    mem[8'h07] = 16'h005E;
    mem[8'h08] = 16'h005E;
    mem[8'h09] = 16'h005E;
    mem[8'h0A] = 16'hAFF6;
    mem[8'hFF] = 16'h1234;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.done    = 1'b0;
    bus.cmp_res = 2'b00;
`ifdef FETCH_SINGLE_STEP_EN
    bus.step    = 1'b0;
`endif
    tick();
    tick();
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_d_inst", 32'(bus.d_inst), 32'd0);
    check("rst_run", 32'(bus.run), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    reset     = 1'b0;
    bus.start = 1'b1;
    ref_pc    = 0;
    wait_run(n);
    check("first_run_cycle", 32'(n), 32'd3);

    exec_one(2'b00, 2, 1'b0);
    check("pc_after_first", 32'(bus.pc), 32'h01);
    exec_one(2'b00, 2, 1'b0);
    exec_one(2'b00, 1, 1'b0);
    check("branch_taken_pc", 32'(bus.pc), 32'hA0);
    exec_one(2'b00, 3, 1'b0);
    exec_one(2'b01, 2, 1'b0);
    check("branch_not_taken_pc", 32'(bus.pc), 32'h06);
    exec_one(2'b00, 2, 1'b0);
    exec_one(2'b01, 2, 1'b0);
    exec_one(2'b10, 2, 1'b0);
    exec_one(2'b11, 2, 1'b0);
    check("cond11_never_taken", 32'(bus.pc), 32'h0A);
    exec_one(2'b01, 2, 1'b0);
    check("truncated_target", 32'(bus.pc), 32'hFF);
    exec_one(2'b10, 2, 1'b0);
    check("wrap_pc", 32'(bus.pc), 32'h00);

    exec_one(2'b00, 2, 1'b1);
    bus.start = 1'b1;
    wait_run(n);
    check("resume_run_cycle", 32'(n), 32'd3);
    exec_one(2'b00, 3, 1'b0);

    // reset lands in EXEC, then a stray done
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.done  = 1'b1;
    tick();
    bus.done = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pc", 32'(bus.pc), 32'd0);
    check("abort_run", 32'(bus.run), 32'd0);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_run", 32'(bus.run), 32'd0);
      check("abort_idle", 32'(bus.busy), 32'd0);
    end
    ref_pc = 0;

    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b10;
      mem[i] = w;
    end
    bus.start = 1'b1;
    wait_run(n);
    check("random_first_run", 32'(n), 32'd3);
    for (int k = 0; k < 40; k++)
      exec_one(2'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 1'b0);
    exec_one(2'($urandom_range(0, 2)), 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
